// File: rtl/fifomult_operand_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifomult_operand_feeder                                                  |
// | Buffers (A,B) operand pairs and serialises them into the fifomult2024    |
// | input as two parity-tagged one-cycle strobes with programmable gaps.     |
// | Optional: FIFOMULT_FEEDER_PARITY_INJECT_EN adds per-word parity invert.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifomult_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pair_valid,
  output logic                     pair_ready,
  input  logic [15:0]              pair_a,
  input  logic [15:0]              pair_b,
`ifdef FIFOMULT_FEEDER_PARITY_INJECT_EN
  input  logic                     pair_inj_a,
  input  logic                     pair_inj_b,
`endif
  input  logic                     busy_in,
  output logic [15:0]              data_in,
  output logic                     data_in_parity,
  output logic                     data_in_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              pairs_sent
);

  localparam int                  c_addr_w  = $clog2(DEPTH);
  localparam logic [c_addr_w:0]   c_depth   = DEPTH[c_addr_w:0];
  localparam logic [c_addr_w:0]   c_lvl_one = 1;
  localparam logic [c_addr_w-1:0] c_ptr_one = 1;
  localparam logic [3:0]          c_gap     = GAP[3:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND_A = 3'd1,
    S_GAP_A  = 3'd2,
    S_SEND_B = 3'd3,
    S_GAP_B  = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_gap_cnt, w_gap_nxt;
  logic                  w_load_a, w_load_b;
  logic [15:0]           r_mem_a [DEPTH];
  logic [15:0]           r_mem_b [DEPTH];
  logic [c_addr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_addr_w:0]     r_level;
  logic [15:0]           r_data, r_pairs_sent;
  logic                  r_parity, r_valid;
  logic                  w_full, w_push, w_pop;
  logic                  w_inj_a, w_inj_b;

  assign w_full = (r_level == c_depth);
  assign w_push = pair_valid && !w_full;
  assign w_pop  = (r_state == S_SEND_B);

`ifdef FIFOMULT_FEEDER_PARITY_INJECT_EN
  logic [1:0] r_mem_inj [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push) r_mem_inj[r_wr_ptr] <= {pair_inj_b, pair_inj_a};
  end

  assign w_inj_a = r_mem_inj[r_rd_ptr][0];
  assign w_inj_b = r_mem_inj[r_rd_ptr][1];
`else
  assign w_inj_a = 1'b0;
  assign w_inj_b = 1'b0;
`endif

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= pair_a;
      r_mem_b[r_wr_ptr] <= pair_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_pairs_sent <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + c_ptr_one;
        r_pairs_sent <= r_pairs_sent + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
    end
  end

  // busy_in is consulted only when leaving IDLE or a gap, never in SEND.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0 && !busy_in) begin
          w_state_nxt = S_SEND_A;
          w_load_a    = 1'b1;
        end
      end
      S_SEND_A: begin
        w_state_nxt = S_GAP_A;
        w_gap_nxt   = c_gap;
      end
      S_GAP_A: begin
        if (r_gap_cnt != 4'd0) w_gap_nxt = r_gap_cnt - 4'd1;
        if (r_gap_cnt <= 4'd1 && !busy_in) begin
          w_state_nxt = S_SEND_B;
          w_load_b    = 1'b1;
        end
      end
      S_SEND_B: begin
        w_state_nxt = S_GAP_B;
        w_gap_nxt   = c_gap;
      end
      S_GAP_B: begin
        if (r_gap_cnt != 4'd0) w_gap_nxt = r_gap_cnt - 4'd1;
        if (r_gap_cnt <= 4'd1 && !busy_in) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= 4'd0;
      r_data    <= 16'd0;
      r_parity  <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_valid   <= w_load_a || w_load_b;
      if (w_load_a) begin
        r_data   <= r_mem_a[r_rd_ptr];
        r_parity <= (^r_mem_a[r_rd_ptr]) ^ w_inj_a;
      end else if (w_load_b) begin
        r_data   <= r_mem_b[r_rd_ptr];
        r_parity <= (^r_mem_b[r_rd_ptr]) ^ w_inj_b;
      end
    end
  end

  assign pair_ready     = !w_full;
  assign data_in        = r_data;
  assign data_in_parity = r_parity;
  assign data_in_valid  = r_valid;
  assign level          = r_level;
  assign pairs_sent     = r_pairs_sent;

endmodule
`default_nettype wire

// File: doc/fifomult_operand_feeder.md
Name: fifomult_operand_feeder

Overview:
- Upstream stage of the fifomult2024 multiplier.
- Accepts operand pairs (A, B) on a valid/ready interface and buffers them in a small pair FIFO.
- Serialises each pair onto the multiplier's single-word input as two one-cycle data_in_valid pulses (A, then B), each with its even-parity bit.
- Honours the multiplier's busy_out back-pressure and inserts programmable idle gaps between pulses.

Parameters:
- DEPTH, 4, pair FIFO depth in pairs; power of 2, minimum 2.
- GAP, 1, idle cycles (data_in_valid low) after every pulse; range 1..15.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pair_valid  in  1  upstream offers a pair.
- pair_ready  out  1  feeder can accept a pair.
- pair_a  in  16  operand A, signed.
- pair_b  in  16  operand B, signed.
- busy_in  in  1  multiplier busy_out; no new pulse may start while high.
- data_in  out  16  word to multiplier.
- data_in_parity  out  1  even parity of data_in.
- data_in_valid  out  1  one-cycle word strobe.
- level  out  $clog2(DEPTH)+1  pairs currently stored.
- pairs_sent  out  16  count of fully transmitted pairs.

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, state IDLE, gap counter 0, all outputs 0 except pair_ready=1 on release. data_in_valid drops immediately. A partially sent pair (A sent, B not) is discarded, not resent.
- Push: occurs on a rising edge with pair_valid && pair_ready.
  - pair_ready = !full, derived from registered state only.
  - A pop in the same cycle does not make pair_ready high while full.
  - pair_valid while full is ignored; no overflow error.
- Pointers wrap modulo DEPTH; level is exact in 0..DEPTH.
- Registered FSM, outputs from registers:
  - IDLE: if level>0 and busy_in==0 -> SEND_A. Load data_in=head.A and data_in_parity=^head.A.
  - SEND_A: data_in_valid=1 for exactly one cycle -> GAP_A, gap counter=GAP.
  - GAP_A: data_in_valid=0. Decrement the counter. When it reaches 0 and busy_in==0 -> SEND_B, loading head.B. Otherwise hold.
  - SEND_B: data_in_valid=1 for one cycle. Pop head and increment pairs_sent (wraps 0xFFFF->0x0000) on this edge -> GAP_B, counter=GAP.
  - GAP_B: as GAP_A, then -> IDLE.
- Latency: pair pushed at edge E0 into an empty FIFO with busy_in low gives data_in_valid(A) high between E1 and E2.
  - With GAP=1, B is high between E3 and E4.
  - The next pair's A starts no earlier than E5.
- busy_in is sampled only in IDLE/GAP states. It has no effect during a SEND cycle, so an in-flight pulse always completes.
- data_in and data_in_parity hold their last value while data_in_valid=0.
- Simultaneous push and pop when not full: both take effect; level unchanged.

Optional Feature:
- Macro: FIFOMULT_FEEDER_PARITY_INJECT_EN.
- Defined: adds inputs pair_inj_a and pair_inj_b (1 bit each), stored with the pair. When set, the corresponding word's data_in_parity is inverted. This exercises the multiplier's data_in_parity_error path.
- Undefined: ports absent; parity is always correct even parity.

Test Plan:
- Reset then single pair A=0x0003, B=0x0007, GAP=1, busy_in=0:
  - data_in_valid pulses carry 0x0003/parity 0, then 0x0007/parity 1, two cycles apart.
  - pairs_sent=1.
  - level returns to 0.
- Push 5 pairs back-to-back with DEPTH=4 and busy_in held high:
  - pair_ready falls after the 4th push; 5th is held, level=4.
  - Release busy_in: all 5 pairs are emitted in order (4 buffered, the 5th accepted once a slot frees).
- Assert busy_in for 10 cycles during GAP_A of pair (0x8000, 0xFFFF):
  - B (0xFFFF, parity 0) is issued exactly 1 cycle after busy_in falls.
  - No extra or duplicate pulses.
- Assert rst_n=0 mid-pair, after A sent:
  - data_in_valid=0 and level=0 asynchronously.
  - After release, the next pushed pair starts from A; pairs_sent=0.
- Preset pairs_sent via 65535 transfers (or force), then send one more pair: pairs_sent=0x0000.
- With FIFOMULT_FEEDER_PARITY_INJECT_EN, pair (0x0001, 0x0001) with inj_a=1, inj_b=0: parities are 0 then 1.
